// File: rtl/pipe_ctrl_pkg.sv
// Shared types and width constants for the pipeline hazard/redirect controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_ST_RUN      = 2'd0,
        PIPE_ST_BUSY     = 2'd1,
        PIPE_ST_REDIRECT = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_ADDR_W      = 32;
    localparam int unsigned PIPE_FLUSH_CNT_W = 2;
    localparam int unsigned PIPE_PERF_W      = 32;

    // Counter width able to hold the value 'limit'; at least one bit.
    function automatic int unsigned pipe_cnt_w(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Bus-busy watchdog: saturating busy-cycle counter and sticky timeout flag.
module pipe_ctrl_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic timeout
);

    localparam int unsigned CNT_W = pipe_cnt_w(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BUSY_TIMEOUT);

    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_cnt_nxt;

    always_comb begin
        busy_cnt_nxt = busy_cnt;
        if (clear) begin
            busy_cnt_nxt = '0;
        end else if (count_en && (busy_cnt != LIMIT)) begin
            busy_cnt_nxt = busy_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            busy_cnt <= busy_cnt_nxt;
            if ((BUSY_TIMEOUT != 0) && count_en && (busy_cnt_nxt == LIMIT)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and redirect controller for the 5-stage RV32I core.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = PIPE_ADDR_W,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    input  logic              load_use_i,
    input  logic              mem_busy_i,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              flush_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_id_ex_o,
    output logic              timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PIPE_PERF_W-1:0] perf_stall_cyc_o,
    output logic [PIPE_PERF_W-1:0] perf_flush_cnt_o
`endif
);

    localparam logic [PIPE_FLUSH_CNT_W-1:0] FLUSH_RELOAD = PIPE_FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pipe_state_e                 state_q, state_d;
    logic                        pend_q, pend_d;
    logic [ADDR_W-1:0]           pend_addr_q, pend_addr_d;
    logic [PIPE_FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic              eval_run;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              hold_pc;
    logic              hold_if_id;
    logic              hold_id_ex;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              wd_en;
    logic              wd_clr;
    logic              timeout;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        flush_cnt_d = flush_cnt_q;
        eval_run    = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = '0;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        wd_en       = 1'b0;
        wd_clr      = 1'b0;

        unique case (state_q)
            PIPE_ST_RUN: eval_run = 1'b1;

            PIPE_ST_BUSY: begin
                if (mem_busy_i) begin
                    hold_pc    = 1'b1;
                    hold_if_id = 1'b1;
                    hold_id_ex = 1'b1;
                    wd_en      = 1'b1;
                    if (jump_en_i && !pend_q) begin
                        pend_d      = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else begin
                    wd_clr = 1'b1;
                    if (pend_q) begin
                        state_d = PIPE_ST_REDIRECT;
                    end else begin
                        // Bus released with nothing captured: this cycle is an ordinary RUN cycle.
                        state_d  = PIPE_ST_RUN;
                        eval_run = 1'b1;
                    end
                end
            end

            PIPE_ST_REDIRECT: begin
                if (mem_busy_i || (!pend_q && jump_en_i)) begin
                    eval_run = 1'b1;
                end else if (pend_q) begin
                    jump_en     = 1'b1;
                    jump_addr   = pend_addr_q;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    pend_d      = 1'b0;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = (FLUSH_RELOAD != '0) ? PIPE_ST_REDIRECT : PIPE_ST_RUN;
                end else if (flush_cnt_q != '0) begin
                    flush_if_id = 1'b1;
                    flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q == PIPE_FLUSH_CNT_W'(1)) begin
                        state_d = PIPE_ST_RUN;
                    end
                end else begin
                    state_d = PIPE_ST_RUN;
                end
            end

            default: state_d = PIPE_ST_RUN;
        endcase

        if (eval_run) begin
            if (mem_busy_i) begin
                hold_pc     = 1'b1;
                hold_if_id  = 1'b1;
                hold_id_ex  = 1'b1;
                flush_cnt_d = '0;
                state_d     = PIPE_ST_BUSY;
                if (jump_en_i && !pend_q) begin
                    pend_d      = 1'b1;
                    pend_addr_d = jump_addr_i;
                end
            end else if (jump_en_i) begin
                jump_en     = 1'b1;
                jump_addr   = jump_addr_i;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = (FLUSH_RELOAD != '0) ? PIPE_ST_REDIRECT : PIPE_ST_RUN;
            end else if (load_use_i) begin
                hold_pc     = 1'b1;
                hold_if_id  = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = PIPE_ST_RUN;
            end else if (hold_flag_i) begin
                hold_pc    = 1'b1;
                hold_if_id = 1'b1;
                hold_id_ex = 1'b1;
                state_d    = PIPE_ST_RUN;
            end else begin
                state_d = PIPE_ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PIPE_ST_RUN;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_ctrl_wdog #(
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .count_en(wd_en),
        .clear   (wd_clr),
        .timeout (timeout)
    );

    // Outputs are forced low while reset is asserted; a flush always overrides a hold on the same register.
    assign jump_en_o     = rst_n & jump_en;
    assign jump_addr_o   = (rst_n && jump_en) ? jump_addr : '0;
    assign hold_pc_o     = rst_n & hold_pc;
    assign flush_if_id_o = rst_n & flush_if_id;
    assign hold_if_id_o  = rst_n & hold_if_id & ~flush_if_id;
    assign flush_id_ex_o = rst_n & flush_id_ex;
    assign hold_id_ex_o  = rst_n & hold_id_ex & ~flush_id_ex;
    assign timeout_o     = rst_n & timeout;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (hold_pc_o) begin
                perf_stall_cyc_o <= perf_stall_cyc_o + 1'b1;
            end
            if (jump_en_o) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: dut_a (FLUSH_CYCLES=1, BUSY_TIMEOUT=8), dut_b (FLUSH_CYCLES=3, watchdog off).
module tb_pipe_ctrl;

    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] JUMP  = 7'b1001010;
    localparam logic [6:0] LU    = 7'b0110010;
    localparam logic [6:0] HOLD  = 7'b0110100;
    localparam logic [6:0] FLIF  = 7'b0001000;
    localparam logic [6:0] TOUT  = 7'b0000001;

    logic        clk;
    logic        rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_flag;
    logic        load_use;
    logic        mem_busy;

    logic        jump_en_a, hold_pc_a, hold_if_id_a, flush_if_id_a, hold_id_ex_a, flush_id_ex_a, timeout_a;
    logic        jump_en_b, hold_pc_b, hold_if_id_b, flush_if_id_b, hold_id_ex_b, flush_id_ex_b, timeout_b;
    logic [31:0] addr_a, addr_b;
    logic [6:0]  sig_a, sig_b;

    int unsigned checks;
    int unsigned failures;

    assign sig_a = {jump_en_a, hold_pc_a, hold_if_id_a, flush_if_id_a, hold_id_ex_a, flush_id_ex_a, timeout_a};
    assign sig_b = {jump_en_b, hold_pc_b, hold_if_id_b, flush_if_id_b, hold_id_ex_b, flush_id_ex_b, timeout_b};

    pipe_ctrl #(
        .ADDR_W      (32),
        .FLUSH_CYCLES(1),
        .BUSY_TIMEOUT(8)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .hold_flag_i  (hold_flag),
        .load_use_i   (load_use),
        .mem_busy_i   (mem_busy),
        .jump_en_o    (jump_en_a),
        .jump_addr_o  (addr_a),
        .hold_pc_o    (hold_pc_a),
        .hold_if_id_o (hold_if_id_a),
        .flush_if_id_o(flush_if_id_a),
        .hold_id_ex_o (hold_id_ex_a),
        .flush_id_ex_o(flush_id_ex_a),
        .timeout_o    (timeout_a)
    );

    pipe_ctrl #(
        .ADDR_W      (32),
        .FLUSH_CYCLES(3),
        .BUSY_TIMEOUT(0)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .hold_flag_i  (hold_flag),
        .load_use_i   (load_use),
        .mem_busy_i   (mem_busy),
        .jump_en_o    (jump_en_b),
        .jump_addr_o  (addr_b),
        .hold_pc_o    (hold_pc_b),
        .hold_if_id_o (hold_if_id_b),
        .flush_if_id_o(flush_if_id_b),
        .hold_id_ex_o (hold_id_ex_b),
        .flush_id_ex_o(flush_id_ex_b),
        .timeout_o    (timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic j, input logic [31:0] ad, input logic hf, input logic lu, input logic mb);
        jump_en   = j;
        jump_addr = ad;
        hold_flag = hf;
        load_use  = lu;
        mem_busy  = mb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        settle();
        check("rst_sig_a", 64'(sig_a), 64'(IDLE));
        check("rst_addr_a", 64'(addr_a), 64'h0);
        check("rst_sig_b", 64'(sig_b), 64'(IDLE));

        tick(); rst_n = 1'b1; drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("idle_a", 64'(sig_a), 64'(IDLE));

        // Test 1: single-cycle jump
        tick(); drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        settle();
        check("t1_jump_a", 64'(sig_a), 64'(JUMP));
        check("t1_addr_a", 64'(addr_a), 64'h40);
        check("t1_jump_b", 64'(sig_b), 64'(JUMP));
        check("t1_addr_b", 64'(addr_b), 64'h40);
        tick(); drive(1'b0, 32'hdead_beef, 1'b0, 1'b0, 1'b0);
        settle();
        check("t1_after_a", 64'(sig_a), 64'(IDLE));
        check("t1_addr_zero_a", 64'(addr_a), 64'h0);
        check("t1_flush2_b", 64'(sig_b), 64'(FLIF));
        tick(); settle();
        check("t1_flush3_b", 64'(sig_b), 64'(FLIF));
        tick(); settle();
        check("t1_done_b", 64'(sig_b), 64'(IDLE));

        // Test 2: load-use bubble, then hold, then priority jump over lower requests
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        settle();
        check("t2_lu_a", 64'(sig_a), 64'(LU));
        check("t2_lu_b", 64'(sig_b), 64'(LU));
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t2_after_a", 64'(sig_a), 64'(IDLE));
        tick(); drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        settle();
        check("hold_a", 64'(sig_a), 64'(HOLD));
        tick(); drive(1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
        settle();
        check("prio_jump_a", 64'(sig_a), 64'(JUMP));
        check("prio_addr_a", 64'(addr_a), 64'h44);
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("prio_after_a", 64'(sig_a), 64'(IDLE));
        tick(); tick(); settle();
        check("prio_done_b", 64'(sig_b), 64'(IDLE));

        // Test 3: jump captured during busy, replayed once
        tick(); drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        settle();
        check("t3_c1_a", 64'(sig_a), 64'(HOLD));
        check("t3_c1_addr_a", 64'(addr_a), 64'h0);
        for (int i = 2; i <= 3; i++) begin
            tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            settle();
            check("t3_busy_a", 64'(sig_a), 64'(HOLD));
        end
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t3_fall_a", 64'(sig_a), 64'(IDLE));
        tick(); settle();
        check("t3_replay_a", 64'(sig_a), 64'(JUMP));
        check("t3_replay_addr_a", 64'(addr_a), 64'h100);
        check("t3_replay_b", 64'(sig_b), 64'(JUMP));
        check("t3_replay_addr_b", 64'(addr_b), 64'h100);
        tick(); settle();
        check("t3_once_a", 64'(sig_a), 64'(IDLE));
        tick(); tick(); settle();
        check("t3_done_b", 64'(sig_b), 64'(IDLE));

        // Test 4: repeated jump during busy -> only first target replayed
        tick(); drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        settle();
        check("t4_c1_a", 64'(sig_a), 64'(HOLD));
        for (int i = 2; i <= 4; i++) begin
            tick(); drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
            settle();
            check("t4_busy_a", 64'(sig_a), 64'(HOLD));
        end
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t4_fall_a", 64'(sig_a), 64'(IDLE));
        tick(); settle();
        check("t4_replay_a", 64'(sig_a), 64'(JUMP));
        check("t4_replay_addr_a", 64'(addr_a), 64'h200);
        tick(); settle();
        check("t4_once_a", 64'(sig_a), 64'(IDLE));
        check("t4_once_addr_a", 64'(addr_a), 64'h0);
        tick(); tick(); settle();
        check("t4_done_b", 64'(sig_b), 64'(IDLE));

        // Test 5: watchdog after 8 BUSY-state cycles (first busy cycle is still RUN)
        for (int i = 1; i <= 20; i++) begin
            tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            settle();
            check("t5_wdog_a", 64'(sig_a), 64'(HOLD | ((i >= 10) ? TOUT : IDLE)));
            check("t5_nowdog_b", 64'(sig_b), 64'(HOLD));
        end
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t5_sticky_a", 64'(sig_a), 64'(TOUT));
        check("t5_idle_b", 64'(sig_b), 64'(IDLE));
        tick(); settle();
        check("t5_sticky2_a", 64'(sig_a), 64'(TOUT));
        tick(); rst_n = 1'b0; #1;
        check("t5_rst_a", 64'(sig_a), 64'(IDLE));
        tick(); rst_n = 1'b1;
        settle();
        check("t5_cleared_a", 64'(sig_a), 64'(IDLE));

        // Test 6: three-cycle if_id flush, then reset in the middle of a redirect
        tick(); drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        settle();
        check("t6_c1_b", 64'(sig_b), 64'(JUMP));
        check("t6_c1_addr_b", 64'(addr_b), 64'h80);
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t6_c2_b", 64'(sig_b), 64'(FLIF));
        check("t6_c2_addr_b", 64'(addr_b), 64'h0);
        tick(); settle();
        check("t6_c3_b", 64'(sig_b), 64'(FLIF));
        tick(); settle();
        check("t6_c4_b", 64'(sig_b), 64'(IDLE));
        tick(); drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        settle();
        check("t6_r1_b", 64'(sig_b), 64'(JUMP));
        tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("t6_pre_rst_b", 64'(sig_b), 64'(FLIF));
        rst_n = 1'b0;
        #1;
        check("t6_rst_b", 64'(sig_b), 64'(IDLE));
        check("t6_rst_a", 64'(sig_a), 64'(IDLE));
        tick(); rst_n = 1'b1;
        settle();
        check("t6_post_b", 64'(sig_b), 64'(IDLE));
        tick(); settle();
        check("t6_post2_b", 64'(sig_b), 64'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline hazard and redirect controller for the 5-stage RV32I core.
- Collects jump and hold requests from ex, load-use hazards from id, and a multi-cycle busy from the load/store bus unit.
- Drives the PC redirect to pc_reg and the hold/flush controls for the if_id and id_ex pipeline registers.
- Captures a branch or jump that resolves while the bus is busy, and replays it once the stall ends.

Parameters:
ADDR_W, 32, width of PC and jump address.
FLUSH_CYCLES, 1, number of consecutive cycles flush_if_id_o stays high after a redirect (1..4).
BUSY_TIMEOUT, 255, number of BUSY cycles before timeout_o sets; 0 disables the watchdog.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
jump_en_i  in  1  ex: branch/jump taken (combinational, same cycle).
jump_addr_i  in  ADDR_W  ex: target address.
hold_flag_i  in  1  ex: one-cycle hold request.
load_use_i  in  1  id: rs1/rs2 depends on the load currently in ex.
mem_busy_i  in  1  bus unit: access in progress, level-sensitive.
jump_en_o  out  1  pc_reg: load jump_addr_o.
jump_addr_o  out  ADDR_W  pc_reg: redirect target.
hold_pc_o  out  1  freeze PC.
hold_if_id_o  out  1  freeze if_id.
flush_if_id_o  out  1  insert NOP into if_id.
hold_id_ex_o  out  1  freeze id_ex.
flush_id_ex_o  out  1  insert NOP into id_ex.
timeout_o  out  1  sticky watchdog error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is RUN; pend_q=0, pend_addr_q=0, flush_cnt=0, busy_cnt=0.
  - All outputs are 0, including timeout_o.
- State RUN. Requests are evaluated combinationally each cycle, highest priority first:
  1. mem_busy_i: hold_pc_o, hold_if_id_o and hold_id_ex_o are 1, with no flush. If jump_en_i is also high, pend_q<=1 and pend_addr_q<=jump_addr_i; jump_en_o stays 0. Next state is BUSY.
  2. jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, all in the same cycle. If FLUSH_CYCLES>1, flush_cnt<=FLUSH_CYCLES-1 and next state is REDIRECT.
  3. load_use_i: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 (one bubble).
  4. hold_flag_i: hold_pc_o, hold_if_id_o and hold_id_ex_o are 1.
  5. Otherwise all outputs are 0.
- State BUSY:
  - All three holds stay 1.
  - jump_en_i is ignored while pend_q=1, because it is a re-evaluation of the same frozen instruction. A first jump_en_i seen with pend_q=0 is captured as in RUN.
  - busy_cnt increments and saturates at BUSY_TIMEOUT. When busy_cnt reaches BUSY_TIMEOUT (and BUSY_TIMEOUT!=0), timeout_o<=1 and stays 1 until reset. The FSM does not force an exit.
  - When mem_busy_i falls (the cycle it reads 0), busy_cnt<=0. If pend_q=1, the next state is REDIRECT. Otherwise the next state is RUN and the holds drop in that cycle.
- State REDIRECT:
  - Entry from BUSY with pend_q=1, first cycle: jump_en_o=1, jump_addr_o=pend_addr_q, flush_if_id_o=1, flush_id_ex_o=1. Then pend_q<=0 and flush_cnt<=FLUSH_CYCLES-1.
  - While flush_cnt>0: flush_if_id_o=1 and flush_cnt decrements.
  - Returns to RUN when flush_cnt reaches 0.
  - If mem_busy_i rises, the state moves to BUSY. pend_q and any new capture follow the RUN rules, and flush_cnt is discarded.
- jump_addr_o is 0 whenever jump_en_o=0.
- A hold and a flush on the same register never occur together: flush wins, and the hold for that register is forced to 0.
- Reset mid-BUSY discards pend_q; the lost redirect is acceptable because the pipeline refetches from the reset vector.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cyc_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cyc_o counts cycles with hold_pc_o=1.
  - perf_flush_cnt_o counts cycles with jump_en_o=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- The shared defines file holds:
  - the state encodings PIPE_ST_RUN=2'd0, PIPE_ST_BUSY=2'd1, PIPE_ST_REDIRECT=2'd2;
  - the width constants.
- One sub-module, pipe_ctrl_wdog, holds the busy_cnt saturating counter and the sticky timeout_o.

Test Plan:
1. jump_en_i=1, jump_addr_i=0x0000_0040 for 1 cycle in RUN -> same cycle jump_en_o=1, jump_addr_o=0x40, both flushes 1, no holds; next cycle all outputs 0.
2. load_use_i=1 for 1 cycle -> hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1, hold_id_ex_o=0; next cycle all outputs 0.
3. mem_busy_i high 3 cycles, jump_en_i=1 with 0x100 in the first of them -> 3 cycles of all holds, jump_en_o=0; the cycle mem_busy_i falls holds drop, next cycle jump_en_o=1 with 0x100 exactly once.
4. mem_busy_i and jump_en_i both held 4 cycles (0x200, then 0x300) -> only 0x200 is replayed, once.
5. BUSY_TIMEOUT=8, mem_busy_i held 20 cycles -> timeout_o rises after the 8th BUSY cycle and stays 1 after busy ends until rst_n pulses low.
6. FLUSH_CYCLES=3, jump to 0x80 -> flush_if_id_o high for 3 consecutive cycles, flush_id_ex_o and jump_en_o only in the first; rst_n low in cycle 2 clears all outputs immediately.
